// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One shift-add or restoring-division step per clock, then one sign-fix cycle.
module muldiv_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       con,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hiloR,
  input  logic             hiloS,
  input  logic             mt_en,
  input  logic             mt_sel,
  input  logic [WIDTH-1:0] mt_data,
  output logic [WIDTH-1:0] hilo_out,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic             stall
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  // Handshake: start is taken only in IDLE with con[3:2]=11; busy stays high
  // until the result is written, and done (with dbz) pulses for one cycle after.
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             bz_q, bz_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             a_neg, b_neg, accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ok;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign a_neg  = con[1] & a[WIDTH-1];
  assign b_neg  = con[1] & b[WIDTH-1];
  assign a_mag  = a_neg ? (~a + 1'b1) : a;
  assign b_mag  = b_neg ? (~b + 1'b1) : b;
  assign accept = (state_q == S_IDLE) && start && (con[3:2] == 2'b11);

  // acc holds the running high product / partial remainder; q holds the
  // low product bits (multiplier shifting out) or the quotient (dividend shifting out).
  assign mul_sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {acc_q, q_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ok    = ~div_diff[WIDTH];
  assign prod      = {acc_q, q_q};
  assign prod_fix  = neg_q ? (~prod + 1'b1) : prod;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    q_d      = q_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    bz_d     = bz_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mt_en) begin
          if (mt_sel) lo_d = mt_data;
          else        hi_d = mt_data;
        end
        if (accept) begin
          is_div_d = con[0];
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          bz_d     = (b == '0);
          acc_d    = '0;
          q_d      = con[0] ? a_mag : b_mag;
          opnd_d   = con[0] ? b_mag : a_mag;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          acc_d = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], div_ok};
        end else begin
          acc_d = mul_sum[WIDTH:1];
          q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (!bz_q) begin
          // Negating |MIN| in WIDTH bits gives MIN back, so MIN / -1 needs no special case.
          lo_d = neg_q  ? (~q_q + 1'b1)   : q_q;
          hi_d = rneg_q ? (~acc_q + 1'b1) : acc_q;
        end
        done_d  = 1'b1;
        dbz_d   = is_div_q & bz_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      bz_q     <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      bz_q     <= bz_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign dbz      = dbz_q;
  assign stall    = busy & (hiloR | start | mt_en);
  assign hilo_out = hiloR ? (hiloS ? lo_q : hi_q) : '0;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed bench for muldiv_hilo_unit at WIDTH=32: results, latency, dbz,
// busy-time stalls, mt writes and mid-operation reset.
module tb_muldiv_hilo_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  con;
  logic [31:0] a;
  logic [31:0] b;
  logic        hiloR;
  logic        hiloS;
  logic        mt_en;
  logic        mt_sel;
  logic [31:0] mt_data;
  logic [31:0] hilo_out;
  logic        busy;
  logic        done;
  logic        dbz;
  logic        stall;

  int checks_cnt;
  int err_cnt;

  muldiv_hilo_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .con(con), .a(a), .b(b),
    .hiloR(hiloR), .hiloS(hiloS), .mt_en(mt_en), .mt_sel(mt_sel),
    .mt_data(mt_data), .hilo_out(hilo_out), .busy(busy), .done(done),
    .dbz(dbz), .stall(stall)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    hiloR = 1'b1;
    hiloS = 1'b0;
    #1;
    check({tag, " hi"}, hilo_out, ehi);
    hiloS = 1'b1;
    #1;
    check({tag, " lo"}, hilo_out, elo);
    hiloR = 1'b0;
  endtask

  task automatic mt_write(input logic sel, input logic [31:0] val);
    mt_en   = 1'b1;
    mt_sel  = sel;
    mt_data = val;
    next_cycle();
    mt_en   = 1'b0;
  endtask

  // Issues one operation and tracks busy/done cycle by cycle. Optionally
  // drives an mt write in the start cycle and a burst of requests mid-run.
  task automatic run_op(input string tag, input logic [3:0] c,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edbz, input logic disturb,
                        input logic [31:0] old_hi,
                        input logic with_mt, input logic [31:0] mt_val);
    int cyc;
    int done_cyc;
    int busy_cnt;
    logic got_dbz;
    start = 1'b1;
    con   = c;
    a     = av;
    b     = bv;
    if (with_mt) begin
      mt_en   = 1'b1;
      mt_sel  = 1'b0;
      mt_data = mt_val;
    end
    next_cycle();
    start = 1'b0;
    mt_en = 1'b0;
    cyc = 1;
    done_cyc = 0;
    busy_cnt = 0;
    got_dbz = 1'b0;
    while (cyc <= 60 && done_cyc == 0) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = cyc;
        got_dbz  = dbz;
      end else if (disturb && cyc == 5) begin
        start   = 1'b1;
        con     = 4'b1100;
        a       = 32'h1;
        b       = 32'h1;
        mt_en   = 1'b1;
        mt_sel  = 1'b0;
        mt_data = 32'hDEAD_BEEF;
        hiloR   = 1'b1;
        hiloS   = 1'b0;
        #1;
        check({tag, " busy stall"}, stall, 1);
        check({tag, " busy hilo_out old"}, hilo_out, old_hi);
      end
      if (done_cyc == 0) begin
        next_cycle();
        start = 1'b0;
        mt_en = 1'b0;
        hiloR = 1'b0;
        cyc++;
      end
    end
    check({tag, " done cycle"}, done_cyc, 34);
    check({tag, " busy cycles"}, busy_cnt, 33);
    check({tag, " dbz"}, got_dbz, edbz);
    read_hilo(tag, ehi, elo);
    next_cycle();
    check({tag, " done one-shot"}, done, 0);
    check({tag, " dbz one-shot"}, dbz, 0);
  endtask

  initial begin
    int done_seen;
    checks_cnt = 0;
    err_cnt    = 0;
    rst = 1'b1; start = 1'b0; con = 4'b0; a = '0; b = '0;
    hiloR = 1'b0; hiloS = 1'b0; mt_en = 1'b0; mt_sel = 1'b0; mt_data = '0;
    repeat (2) next_cycle();
    rst = 1'b0;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset dbz", dbz, 0);
    check("reset hilo_out idle", hilo_out, 0);
    read_hilo("reset", 32'h0, 32'h0);
    hiloR = 1'b1;
    #1;
    check("idle stall", stall, 0);
    hiloR = 1'b0;
    next_cycle();

    run_op("umul max", 4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    run_op("smul -3*5", 4'b1110, 32'hFFFF_FFFD, 32'h5,
           32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    run_op("sdiv -7/2", 4'b1111, 32'hFFFF_FFF9, 32'h2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    mt_write(1'b0, 32'h1234_5678);
    mt_write(1'b1, 32'h9ABC_DEF0);
    read_hilo("mt write", 32'h1234_5678, 32'h9ABC_DEF0);
    next_cycle();
    run_op("udiv by zero", 4'b1101, 32'h55, 32'h0,
           32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

    run_op("sdiv min/-1", 4'b1111, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    run_op("udiv 100/7", 4'b1101, 32'd100, 32'd7,
           32'd2, 32'd14, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    run_op("sdiv 7/-2", 4'b1111, 32'd7, 32'hFFFF_FFFE,
           32'd1, 32'hFFFF_FFFD, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    run_op("umul shift", 4'b1100, 32'h1234_5678, 32'h10,
           32'h1, 32'h2345_6780, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    run_op("smul -2*-2 disturbed", 4'b1110, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
           32'h0, 32'h4, 1'b0, 1'b1, 32'h1, 1'b0, 32'h0);
    run_op("umul with mt", 4'b1100, 32'd3, 32'd4,
           32'h0, 32'd12, 1'b0, 1'b1, 32'hAAAA_0000, 1'b1, 32'hAAAA_0000);

    start = 1'b1;
    con   = 4'b0110;
    a     = 32'd9;
    b     = 32'd9;
    next_cycle();
    start = 1'b0;
    check("bad con ignored", busy, 0);
    read_hilo("bad con", 32'h0, 32'd12);
    next_cycle();

    start = 1'b1;
    con   = 4'b1100;
    a     = 32'h7;
    b     = 32'h9;
    next_cycle();
    start = 1'b0;
    repeat (9) next_cycle();
    check("abort busy cycle 10", busy, 1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    check("abort busy after rst", busy, 0);
    read_hilo("abort", 32'h0, 32'h0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_seen++;
      next_cycle();
    end
    check("abort no done", done_seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, err_cnt);
    $finish;
  end

endmodule
